// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// RV32I load/store unit. Each accepted request runs through a three-state FSM:
//   Idle -> Access -> Done -> Idle
// A misaligned access or an illegal funct3 skips Access and goes straight to
// Done with mem_err_o set. No memory strobe is raised and no register write
// happens for such a request.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mem_req_i, mem_we_i      upstream request pulse; 1 = store, 0 = load
//   mem_funct3_i             RV32I width/sign selector (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   mem_addr_i, mem_wdata_i  byte address; store data (unaligned, in the low bits)
//   mem_rd_i                 load destination register
//   mem_ready_o              high only in Idle (request is accepted when req & ready)
//   mem_done_o, mem_err_o    one-cycle completion pulse, with its error flag
//   rd_we_o/rd_addr_o/rd_wdata_o  register-file write port, valid in Done
//   data_addr_o              word-aligned memory address
//   data_read_o/data_write_o memory strobes, held high through Access
//   data_wdata_o, data_be_o  lane-replicated store data and byte enables
//   data_rdata_i, data_ready_i   read word; access-complete handshake
// -----------------------------------------------------------------------------
module mem_stage #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_req_i,
   input  logic                  mem_we_i,
   input  logic [2:0]            mem_funct3_i,
   input  logic [ADDR_WIDTH-1:0] mem_addr_i,
   input  logic [DATA_WIDTH-1:0] mem_wdata_i,
   input  logic [4:0]            mem_rd_i,
   output logic                  mem_ready_o,
   output logic                  mem_done_o,
   output logic                  mem_err_o,
   output logic                  rd_we_o,
   output logic [4:0]            rd_addr_o,
   output logic [DATA_WIDTH-1:0] rd_wdata_o,
   output logic [ADDR_WIDTH-1:0] data_addr_o,
   output logic                  data_read_o,
   output logic                  data_write_o,
   output logic [DATA_WIDTH-1:0] data_wdata_o,
   output logic [3:0]            data_be_o,
   input  logic [DATA_WIDTH-1:0] data_rdata_i,
   input  logic                  data_ready_i
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [2:0] F_B  = 3'd0;
   localparam logic [2:0] F_H  = 3'd1;
   localparam logic [2:0] F_W  = 3'd2;
   localparam logic [2:0] F_BU = 3'd4;
   localparam logic [2:0] F_HU = 3'd5;

   state_t                  state_q, state_d;
   logic                    we_q;
   logic [2:0]              funct3_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [4:0]              rd_q;
   logic                    err_q;
   logic [DATA_WIDTH-1:0]   load_q;

   logic                    accept;
   logic                    access_exit;
   logic                    req_err;
   logic [15:0]             lane_h;
   logic [7:0]              lane_b;
   logic [DATA_WIDTH-1:0]   load_val;
   logic [3:0]              be_val;
   logic [DATA_WIDTH-1:0]   store_val;

   assign accept      = mem_req_i && (state_q == IDLE);
   // data_ready_i only matters while the memory access is actually in flight.
   assign access_exit = data_ready_i && (state_q == ACCESS);

   // Classify the incoming request. Store funct3 4/5 are illegal even though
   // the same codes are legal loads (LBU/LHU).
   // NOTE: every signal written in an always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      req_err = 1'b1;
      if (mem_we_i) begin
         case (mem_funct3_i)
            F_B:     req_err = 1'b0;
            F_H:     req_err = mem_addr_i[0];
            F_W:     req_err = |mem_addr_i[1:0];
            default: req_err = 1'b1;
         endcase
      end else begin
         case (mem_funct3_i)
            F_B, F_BU: req_err = 1'b0;
            F_H, F_HU: req_err = mem_addr_i[0];
            F_W:       req_err = |mem_addr_i[1:0];
            default:   req_err = 1'b1;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (mem_req_i)    state_d = req_err ? DONE : ACCESS;
         ACCESS:  if (data_ready_i) state_d = DONE;
         DONE:                      state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
   end

   // Load lane selection from the latched address. The halfword is picked by
   // addr[1], then the byte inside it by addr[0].
   always_comb begin
      lane_h   = addr_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
      lane_b   = addr_q[0] ? lane_h[15:8] : lane_h[7:0];
      load_val = data_rdata_i;
      case (funct3_q)
         F_B:     load_val = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
         F_H:     load_val = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
         F_BU:    load_val = {{(DATA_WIDTH-8){1'b0}}, lane_b};
         F_HU:    load_val = {{(DATA_WIDTH-16){1'b0}}, lane_h};
         default: load_val = data_rdata_i;
      endcase
   end

   // Store lanes: the data is replicated across the word so that the byte
   // enables alone select the lanes that are written.
   always_comb begin
      be_val    = 4'b1111;
      store_val = wdata_q;
      case (funct3_q[1:0])
         2'd0: begin
            be_val    = 4'b0001 << addr_q[1:0];
            store_val = {4{wdata_q[7:0]}};
         end
         2'd1: begin
            be_val    = 4'b0011 << addr_q[1:0];
            store_val = {2{wdata_q[15:0]}};
         end
         default: begin
            be_val    = 4'b1111;
            store_val = wdata_q;
         end
      endcase
   end

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rd_q     <= 5'd0;
         err_q    <= 1'b0;
         load_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q     <= mem_we_i;
            funct3_q <= mem_funct3_i;
            addr_q   <= mem_addr_i;
            wdata_q  <= mem_wdata_i;
            rd_q     <= mem_rd_i;
            err_q    <= req_err;
         end
         if (access_exit) begin
            load_q <= load_val;
         end
      end
   end

   assign mem_ready_o  = (state_q == IDLE);
   assign mem_done_o   = (state_q == DONE);
   assign mem_err_o    = (state_q == DONE) && err_q;
   assign rd_we_o      = (state_q == DONE) && !err_q && !we_q && (rd_q != 5'd0);
   assign rd_addr_o    = rd_q;
   assign rd_wdata_o   = load_q;

   // Strobes exist only in Access. An erroring request never reaches Access,
   // so it can never raise them.
   assign data_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign data_read_o  = (state_q == ACCESS) && !we_q;
   assign data_write_o = (state_q == ACCESS) && we_q;
   assign data_be_o    = (state_q == ACCESS) ? be_val : 4'b0000;
   assign data_wdata_o = store_val;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//
// Drives directed vectors from a table, then randomized transactions whose
// expected results come from a behavioural model. Hand-written sequences cover
// reset, reset-versus-request, and reset in the middle of an access.
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req_i, mem_we_i;
   logic [2:0]  mem_funct3_i;
   logic [31:0] mem_addr_i, mem_wdata_i;
   logic [4:0]  mem_rd_i;
   logic        mem_ready_o, mem_done_o, mem_err_o;
   logic        rd_we_o;
   logic [4:0]  rd_addr_o;
   logic [31:0] rd_wdata_o, data_addr_o;
   logic        data_read_o, data_write_o;
   logic [31:0] data_wdata_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_rdata_i;
   logic        data_ready_i;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk          (clk),
      .rst          (rst),
      .mem_req_i    (mem_req_i),
      .mem_we_i     (mem_we_i),
      .mem_funct3_i (mem_funct3_i),
      .mem_addr_i   (mem_addr_i),
      .mem_wdata_i  (mem_wdata_i),
      .mem_rd_i     (mem_rd_i),
      .mem_ready_o  (mem_ready_o),
      .mem_done_o   (mem_done_o),
      .mem_err_o    (mem_err_o),
      .rd_we_o      (rd_we_o),
      .rd_addr_o    (rd_addr_o),
      .rd_wdata_o   (rd_wdata_o),
      .data_addr_o  (data_addr_o),
      .data_read_o  (data_read_o),
      .data_write_o (data_write_o),
      .data_wdata_o (data_wdata_o),
      .data_be_o    (data_be_o),
      .data_rdata_i (data_rdata_i),
      .data_ready_i (data_ready_i)
   );

   typedef struct {
      bit          we;
      logic [2:0]  f;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [4:0]  rd;
      int          delay;
      bit          exp_err;
      bit          exp_rd_we;
      logic [31:0] exp_rd_wdata;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
   } txn_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic txn_t mk(input bit we, input logic [2:0] f, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input logic [4:0] rd, input int delay, input bit e_err,
                               input bit e_rd_we, input logic [31:0] e_rd_wdata,
                               input logic [3:0] e_be, input logic [31:0] e_wdata);
      txn_t t;
      t.we = we; t.f = f; t.addr = addr; t.wdata = wdata; t.rdata = rdata; t.rd = rd;
      t.delay = delay; t.exp_err = e_err; t.exp_rd_we = e_rd_we;
      t.exp_rd_wdata = e_rd_wdata; t.exp_be = e_be; t.exp_wdata = e_wdata;
      return t;
   endfunction

   // Reference model. The access size is 1 << funct3[1:0] bytes, an access is
   // misaligned when the address is not a multiple of the size, and the loaded
   // lane is obtained by shifting the word right by 8 * byte offset.
   function automatic txn_t model(input txn_t t);
      txn_t        r;
      int unsigned size, off;
      logic [31:0] lane;
      bit          illegal;
      r       = t;
      size    = 1 << t.f[1:0];
      off     = t.addr[1:0];
      illegal = t.we ? (t.f >= 3) : (t.f == 3 || t.f >= 6);
      r.exp_err = illegal || ((t.addr % size) != 0);
      lane = t.rdata >> (8 * off);
      case (t.f)
         3'd0:    r.exp_rd_wdata = 32'($signed(lane[7:0]));
         3'd1:    r.exp_rd_wdata = 32'($signed(lane[15:0]));
         3'd4:    r.exp_rd_wdata = lane & 32'h0000_00FF;
         3'd5:    r.exp_rd_wdata = lane & 32'h0000_FFFF;
         default: r.exp_rd_wdata = t.rdata;
      endcase
      r.exp_rd_we = !t.we && !r.exp_err && (t.rd != 5'd0);
      r.exp_be    = 4'(((1 << size) - 1) << off);
      if (size == 1)      r.exp_wdata = t.wdata[7:0] * 32'h0101_0101;
      else if (size == 2) r.exp_wdata = t.wdata[15:0] * 32'h0001_0001;
      else                r.exp_wdata = t.wdata;
      return r;
   endfunction

   // Runs one request from Idle to Idle. With extra_req set, random requests
   // are kept on mem_req_i for the whole Access and Done period. They must
   // be ignored.
   task automatic run_txn(input txn_t t, input bit extra_req, input string tag);
      int acc;
      logic [31:0] exp_addr;
      exp_addr = t.addr & 32'hFFFF_FFFC;
      @(negedge clk);
      check({tag, " ready_idle"}, 32'(mem_ready_o), 32'd1);
      mem_req_i    = 1'b1;
      mem_we_i     = t.we;
      mem_funct3_i = t.f;
      mem_addr_i   = t.addr;
      mem_wdata_i  = t.wdata;
      mem_rd_i     = t.rd;
      data_ready_i = 1'($urandom);
      data_rdata_i = $urandom;
      @(posedge clk); #1;
      acc = 0;
      while (!mem_done_o && acc < 40) begin
         acc++;
         check({tag, " read_strobe"},  32'(data_read_o),  32'(!t.we));
         check({tag, " write_strobe"}, 32'(data_write_o), 32'(t.we));
         check({tag, " data_addr"},    data_addr_o,       exp_addr);
         if (t.we) begin
            check({tag, " be"},    32'(data_be_o), 32'(t.exp_be));
            check({tag, " wdata"}, data_wdata_o,   t.exp_wdata);
         end
         @(negedge clk);
         if (extra_req) begin
            mem_req_i    = 1'b1;
            mem_we_i     = 1'($urandom);
            mem_funct3_i = 3'($urandom);
            mem_addr_i   = $urandom;
            mem_wdata_i  = $urandom;
            mem_rd_i     = 5'($urandom);
         end else begin
            mem_req_i = 1'b0;
         end
         data_ready_i = (acc > t.delay);
         data_rdata_i = (acc > t.delay) ? t.rdata : $urandom;
         @(posedge clk); #1;
      end
      check({tag, " access_cycles"}, 32'(acc), t.exp_err ? 32'd0 : 32'(t.delay + 1));
      check({tag, " done"},          32'(mem_done_o),   32'd1);
      check({tag, " err"},           32'(mem_err_o),    32'(t.exp_err));
      check({tag, " rd_we"},         32'(rd_we_o),      32'(t.exp_rd_we));
      check({tag, " rd_addr"},       32'(rd_addr_o),    32'(t.rd));
      if (t.exp_rd_we) check({tag, " rd_wdata"}, rd_wdata_o, t.exp_rd_wdata);
      check({tag, " strobes_done"},  {30'd0, data_read_o, data_write_o}, 32'd0);
      check({tag, " be_done"},       32'(data_be_o),    32'd0);
      @(negedge clk);
      mem_req_i    = 1'b0;
      data_ready_i = 1'b0;
      @(posedge clk); #1;
      check({tag, " done_pulse"},  32'(mem_done_o),  32'd0);
      check({tag, " back_idle"},   32'(mem_ready_o), 32'd1);
      check({tag, " idle_strobe"}, {30'd0, data_read_o, data_write_o}, 32'd0);
   endtask

   txn_t vecs[$];

   initial begin
      // Directed vectors. Store expectations for be/wdata apply only to the
      // legal stores; load be/wdata are left at zero and are not checked.
      vecs.push_back(mk(0, 3'd2, 32'h100, 0, 32'hDEAD_BEEF, 5'd5, 0, 0, 1, 32'hDEAD_BEEF, 0, 0));
      vecs.push_back(mk(0, 3'd0, 32'h103, 0, 32'h80FF_0000, 5'd6, 0, 0, 1, 32'hFFFF_FF80, 0, 0));
      vecs.push_back(mk(0, 3'd4, 32'h103, 0, 32'h80FF_0000, 5'd6, 1, 0, 1, 32'h0000_0080, 0, 0));
      vecs.push_back(mk(1, 3'd1, 32'h202, 32'h1234_ABCD, 0, 5'd9, 0, 0, 0, 0, 4'b1100, 32'hABCD_ABCD));
      vecs.push_back(mk(0, 3'd2, 32'h101, 0, 32'h1111_1111, 5'd4, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3'd1, 32'h102, 0, 32'h80FF_0000, 5'd7, 2, 0, 1, 32'hFFFF_80FF, 0, 0));
      vecs.push_back(mk(0, 3'd5, 32'h102, 0, 32'h80FF_0000, 5'd7, 0, 0, 1, 32'h0000_80FF, 0, 0));
      vecs.push_back(mk(0, 3'd0, 32'h000, 0, 32'h0000_007F, 5'd0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 3'd0, 32'h301, 32'h0000_00A5, 0, 5'd3, 1, 0, 0, 0, 4'b0010, 32'hA5A5_A5A5));
      vecs.push_back(mk(1, 3'd2, 32'h400, 32'hCAFE_F00D, 0, 5'd8, 0, 0, 0, 0, 4'b1111, 32'hCAFE_F00D));
      vecs.push_back(mk(1, 3'd2, 32'h402, 32'hCAFE_F00D, 0, 5'd8, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3'd3, 32'h000, 0, 32'h1234_5678, 5'd2, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 3'd4, 32'h000, 32'h55, 0, 5'd2, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3'd1, 32'h101, 0, 32'h1234_5678, 5'd2, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3'd0, 32'h001, 0, 32'h0000_7F00, 5'd31, 0, 0, 1, 32'h0000_007F, 0, 0));
   end

   initial begin
      txn_t t;
      rst          = 1'b1;
      mem_req_i    = 1'b0;
      mem_we_i     = 1'b0;
      mem_funct3_i = 3'd0;
      mem_addr_i   = '0;
      mem_wdata_i  = '0;
      mem_rd_i     = '0;
      data_rdata_i = '0;
      data_ready_i = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst ready",     32'(mem_ready_o), 32'd1);
      check("rst done",      32'(mem_done_o),  32'd0);
      check("rst err",       32'(mem_err_o),   32'd0);
      check("rst rd_we",     32'(rd_we_o),     32'd0);
      check("rst strobes",   {30'd0, data_read_o, data_write_o}, 32'd0);
      check("rst be",        32'(data_be_o),   32'd0);
      check("rst data_addr", data_addr_o,      32'd0);
      check("rst rd_wdata",  rd_wdata_o,       32'd0);
      check("rst rd_addr",   32'(rd_addr_o),   32'd0);
      check("rst wdata",     data_wdata_o,     32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed table.
      foreach (vecs[i]) run_txn(vecs[i], 1'b0, $sformatf("vec%0d", i));

      // A load with ready delayed 3 cycles and requests held during Access.
      // The read strobe is held for 4 cycles and only one done pulse follows.
      t = model(mk(0, 3'd2, 32'h600, 0, 32'h0BAD_F00D, 5'd12, 3, 0, 0, 0, 0, 0));
      run_txn(t, 1'b1, "delay3");
      @(posedge clk); #1;
      check("delay3 no_queued", 32'(mem_ready_o), 32'd1);

      // Reset takes priority over a request presented on the same edge.
      @(negedge clk);
      rst = 1'b1; mem_req_i = 1'b1; mem_we_i = 1'b0; mem_funct3_i = 3'd2;
      mem_addr_i = 32'h700; mem_rd_i = 5'd1;
      @(posedge clk); #1;
      check("rst_dom read",  32'(data_read_o), 32'd0);
      check("rst_dom ready", 32'(mem_ready_o), 32'd1);
      @(negedge clk);
      rst = 1'b0; mem_req_i = 1'b0;
      @(posedge clk); #1;
      check("rst_dom after read", 32'(data_read_o), 32'd0);
      check("rst_dom after done", 32'(mem_done_o),  32'd0);

      // Reset in the second Access cycle aborts the access.
      @(negedge clk);
      mem_req_i = 1'b1; mem_we_i = 1'b0; mem_funct3_i = 3'd2;
      mem_addr_i = 32'h500; mem_rd_i = 5'd3; data_ready_i = 1'b0;
      @(posedge clk); #1;
      check("abort access1 read", 32'(data_read_o), 32'd1);
      @(negedge clk);
      mem_req_i = 1'b0;
      @(posedge clk); #1;
      check("abort access2 read", 32'(data_read_o), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort read",  32'(data_read_o), 32'd0);
      check("abort ready", 32'(mem_ready_o), 32'd1);
      check("abort done",  32'(mem_done_o),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("abort no_done", 32'(mem_done_o), 32'd0);
      end
      run_txn(model(mk(0, 3'd2, 32'h504, 0, 32'h600D_CAFE, 5'd3, 0, 0, 0, 0, 0, 0)),
              1'b0, "after_abort");

      // Randomized transactions checked against the model.
      for (int n = 0; n < 300; n++) begin
         txn_t r;
         r.we    = 1'($urandom);
         r.f     = 3'($urandom);
         r.addr  = $urandom & 32'h0000_FFFF;
         r.wdata = $urandom;
         r.rdata = $urandom;
         r.rd    = 5'($urandom);
         r.delay = $urandom_range(0, 3);
         r.exp_err = 0; r.exp_rd_we = 0; r.exp_rd_wdata = 0; r.exp_be = 0; r.exp_wdata = 0;
         run_txn(model(r), (n % 5) == 0, $sformatf("rand%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 Parameter DATA_WIDTH, default 32, data word width; only 32 supported.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 mem_req_i  in  1  upstream pulse: load/store to perform.
REQ-006 mem_we_i  in  1  1=store, 0=load; qualified by mem_req_i.
REQ-007 mem_funct3_i  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 mem_addr_i  in  ADDR_WIDTH  effective byte address (rs1+imm).
REQ-009 mem_wdata_i  in  DATA_WIDTH  store data (rs2), unaligned in low bits.
REQ-010 mem_rd_i  in  5  load destination register.
REQ-011 mem_ready_o  out  1  high only in Idle; request accepted when mem_req_i & mem_ready_o.
REQ-012 mem_done_o  out  1  one-cycle pulse: access finished.
REQ-013 mem_err_o  out  1  valid with mem_done_o: misaligned or illegal funct3.
REQ-014 rd_we_o, rd_addr_o[4:0], rd_wdata_o[DATA_WIDTH-1:0]  out  register-file write port.
REQ-015 data_addr_o  out  ADDR_WIDTH  word-aligned address (addr[1:0]=0).
REQ-016 data_read_o / data_write_o  out  1 each  memory read/write request levels.
REQ-017 data_wdata_o  out  DATA_WIDTH  lane-shifted store data; data_be_o  out  4  byte enables.
REQ-018 data_rdata_i  in  DATA_WIDTH  read word; data_ready_i  in  1  access complete.

Function
REQ-019 FSM states SHALL be Idle, Access, Done.
REQ-020 Idle: on accepted request, latch we, funct3, addr, wdata, rd; go Access, or Done directly if error (REQ-025).
REQ-021 Access: data_read_o=!we or data_write_o=we held high; data_addr_o, data_wdata_o, data_be_o stable; stay until data_ready_i=1, then go Done.
REQ-022 Done: mem_done_o=1 for exactly one cycle; then Idle.
REQ-023 Minimum latency: request accepted cycle N, Access N+1 (ready same cycle), mem_done_o at N+2.
REQ-024 mem_req_i while not Idle SHALL be ignored; no queueing.
REQ-025 Error: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; load funct3 in {3,6,7}; store funct3>=3 -> no memory strobe, Done with mem_err_o=1, rd_we_o=0.
REQ-026 Store lanes: SB be=0001<<a[1:0], data replicated x4; SH be=0011<<a[1:0], halfword replicated x2; SW be=1111.
REQ-027 Load capture: data_rdata_i registered on Access exit; lane selected by latched addr[1:0].
REQ-028 LB/LH sign-extend, LBU/LHU zero-extend to 32 bits; LW pass-through.
REQ-029 rd_we_o=1 in Done only for error-free load with rd!=0; rd_addr_o=latched rd; rd_wdata_o valid in Done.
REQ-030 Stores SHALL never assert rd_we_o.
REQ-031 Strobes SHALL be 0 in Idle and Done; read and write never both high.
REQ-032 data_ready_i outside Access SHALL be ignored.

Reset
REQ-033 rst=1 -> Idle next edge; mem_ready_o=1; mem_done_o, mem_err_o, rd_we_o, data_read_o, data_write_o=0; data_be_o=0; all address/data registers=0.
REQ-034 rst asserted mid-Access SHALL abort: strobes low after that edge, no mem_done_o for the aborted access.
REQ-035 rst dominates a simultaneous mem_req_i; request dropped.

Verification
REQ-036 LW addr 0x100, rdata 0xDEADBEEF, ready on first Access cycle -> done at N+2, rd_we_o=1, rd_wdata_o=0xDEADBEEF.
REQ-037 LB addr 0x103, rdata 0x80FF_0000 -> rd_wdata_o=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-038 SH addr 0x202, wdata 0x1234ABCD -> data_addr_o=0x200, be=1100, data_wdata_o=0xABCDABCD, rd_we_o=0.
REQ-039 LW addr 0x101 -> no data_read_o, done at N+1 with mem_err_o=1, rd_we_o=0.
REQ-040 Load with data_ready_i delayed 3 cycles, second mem_req_i during Access -> data_read_o held 4 cycles, second request ignored, single done pulse.
REQ-041 rst pulse in 2nd Access cycle -> strobe low next cycle, Idle, no done; next LW completes normally.
